// File: rtl/instr_sequencer.sv
// Program sequencer feeding the jericalla datapath.
// Loadable program memory, PC walk, valid/ready issue, halt.
module instr_sequencer #(
  parameter int INSTR_W = 17,
  parameter int DEPTH   = 16,
  parameter int PC_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [PC_W-1:0]    load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic [PC_W:0]      prog_len,
  input  logic               start,
  input  logic               halt_req,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W:0]      issued,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [INSTR_W-1:0] mem [DEPTH];

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W:0]      issued_q, issued_d;
  logic [PC_W:0]      len_q, len_d;
  logic               halt_q, halt_d;
  logic [INSTR_W-1:0] out_q, out_d;

  logic               can_load;
  logic [PC_W:0]      issued_inc;

  assign can_load   = (state_q == IDLE) || (state_q == DONE);
  assign issued_inc = issued_q + 1'b1;

  // Program memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_en && can_load) begin
      mem[load_addr] <= load_data;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      issued_q <= '0;
      len_q    <= '0;
      halt_q   <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      issued_q <= issued_d;
      len_q    <= len_d;
      halt_q   <= halt_d;
      out_q    <= out_d;
    end
  end

  // Next-state: start, fetch (registered read), issue handshake.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    issued_d = issued_q;
    len_d    = len_q;
    halt_d   = halt_q;
    out_d    = out_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pc_d     = '0;
          issued_d = '0;
          halt_d   = 1'b0;
          len_d    = prog_len;
          if (prog_len == '0) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        out_d   = mem[pc_q];
        state_d = ISSUE;
        if (halt_req) halt_d = 1'b1;
      end
      ISSUE: begin
        if (halt_req) halt_d = 1'b1;
        if (instr_ready) begin
          issued_d = issued_inc;
          halt_d   = 1'b0;
          if (issued_inc == len_q) begin
            state_d = DONE;
          end else if (halt_q || halt_req) begin
            state_d = IDLE;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign instr_out   = out_q;
  assign instr_valid = (state_q == ISSUE);
  assign pc          = pc_q;
  assign issued      = issued_q;
  assign busy        = (state_q == FETCH) || (state_q == ISSUE);
  assign done        = (state_q == DONE);

endmodule
